// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic cells: FSM state encodings
// and a constant-evaluable ceiling-log2 used to size counters.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << r) < 64'(value)) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, bout set when the bit
// position has to borrow from the next more significant bit.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b processed LSB-first through one
// full_subtractor cell, with a start/busy/done handshake.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bw_q, bw_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             fs_d, fs_bout;

    full_subtractor u_fs (
        .x    (ra_q[0]),
        .y    (rb_q[0]),
        .bin  (bw_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    always_comb begin
        state_d  = state_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        bw_d     = bw_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                    ra_d    = a;
                    rb_d    = b;
                    res_d   = '0;
                    bw_d    = 1'b0;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                ra_d             = ra_q >> 1;
                rb_d             = rb_q >> 1;
                // New bit enters at the MSB so bit i lands at index i after WIDTH shifts.
                res_d            = res_q >> 1;
                res_d[WIDTH-1]   = fs_d;
                bw_d             = fs_bout;
                cnt_d            = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d  = ST_DONE;
                    diff_d   = res_d;
                    borrow_d = fs_bout;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ra_q     <= '0;
            rb_q     <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            bw_q     <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            bw_q     <= bw_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomised checks of serial_subtractor at WIDTH=8.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    int tests_run;
    int tests_failed;
    int done_cnt;
    int exp_done;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for IDLE, starts one operation and checks latency, busy length and result.
    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] ed, input logic eb);
        int n;
        int busy_n;
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_idle_wait"}, 32'(busy), 32'd0);
        start = 1'b1;
        a     = av;
        b     = bv;
        tick();
        start = 1'b0;
        a     = 8'hx;
        b     = 8'hx;
        exp_done++;
        busy_n = busy ? 1 : 0;
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
            if (busy) busy_n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd8);
        check({tag, "_diff"}, 32'(diff), 32'(ed));
        check({tag, "_borrow"}, 32'(borrow), 32'(eb));
        check({tag, "_busy_len"}, 32'(busy_n), 32'd9);
        tick();
        check({tag, "_done_clr"}, 32'(done), 32'd0);
        check({tag, "_busy_clr"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int d0;
        logic [7:0] ra;
        logic [7:0] rb;
        tests_run    = 0;
        tests_failed = 0;
        done_cnt     = 0;
        exp_done     = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow), 32'd0);
        rst = 1'b0;
        tick();

        run_op("s1", 8'h05, 8'h03, 8'h02, 1'b0);

        run_op("s2", 8'h03, 8'h05, 8'hFE, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s2_hold_diff", 32'(diff), 32'hFE);
            check("s2_hold_borrow", 32'(borrow), 32'd1);
        end

        run_op("s3a", 8'h00, 8'h00, 8'h00, 1'b0);
        run_op("s3b", 8'h00, 8'hFF, 8'h01, 1'b1);
        run_op("s3c", 8'hFF, 8'h00, 8'hFF, 1'b0);

        // Scenario 4: extra start pulses during SHIFT (edge k+2) and DONE (edge k+9).
        d0    = done_cnt;
        start = 1'b1;
        a     = 8'h10;
        b     = 8'h01;
        tick();
        exp_done++;
        start = 1'b0;
        tick();
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h55;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("s4_done", 32'(done), 32'd1);
        check("s4_diff", 32'(diff), 32'h0F);
        check("s4_borrow", 32'(borrow), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("s4_busy_after", 32'(busy), 32'd0);
        for (int i = 0; i < 12; i++) tick();
        check("s4_busy_stay", 32'(busy), 32'd0);
        check("s4_done_count", 32'(done_cnt - d0), 32'd1);
        check("s4_diff_hold", 32'(diff), 32'h0F);

        // Scenario 5: reset on edge k+4 aborts the operation.
        start = 1'b1;
        a     = 8'h22;
        b     = 8'h11;
        tick();
        start = 1'b0;
        d0    = done_cnt;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("s5_busy", 32'(busy), 32'd0);
        check("s5_done", 32'(done), 32'd0);
        check("s5_diff", 32'(diff), 32'd0);
        check("s5_borrow", 32'(borrow), 32'd0);
        for (int i = 0; i < 12; i++) tick();
        check("s5_no_done", 32'(done_cnt - d0), 32'd0);
        run_op("s5_fresh", 8'h80, 8'h01, 8'h7F, 1'b0);

        // Scenario 6: random operands against a reference subtraction.
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            run_op("s6", ra, rb, 8'(ra - rb), (ra < rb));
        end
        tick();
        check("done_total", 32'(done_cnt), 32'(exp_done));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor: it accepts two WIDTH-bit operands on a start pulse and computes a − b LSB-first, one bit per clock, through a single full-subtractor cell with a registered borrow. It complements the combinational adder cells in the arithmetic library: it is the subtract direction, and it trades latency for one-bit datapath area. It sits beside those cells as a reusable datapath element with a start/done handshake for small controllers.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits; legal range ≥ 1.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepted start edge.
- b  input  WIDTH  subtrahend; captured on the accepted start edge.
- busy  output  1  high from the accept edge until the return to IDLE.
- done  output  1  one-cycle pulse; diff and borrow are valid in that cycle.
- diff  output  WIDTH  (a − b) mod 2^WIDTH.
- borrow  output  1  final borrow-out; 1 iff a < b (unsigned).

## Operation
- States:
  - IDLE: waiting for start.
  - SHIFT: one bit processed per clock.
  - DONE: result presented for one cycle.
- IDLE → SHIFT on any edge with start=1:
  - load shift registers ra←a, rb←b.
  - clear the internal result register, the borrow flop bw←0 and the bit counter cnt←0.
- SHIFT, per edge:
  - d = ra[0] ^ rb[0] ^ bw.
  - bw ← (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & bw).
  - ra, rb shift right by one.
  - d shifts into the result register MSB-side, so after WIDTH shifts bit i sits at index i.
  - cnt increments.
- SHIFT → DONE on the edge where cnt == WIDTH−1. That edge processes the last bit and updates diff and borrow from the completed result register and the final bw.
- DONE → IDLE on the next edge, unconditionally.
- start is ignored in SHIFT and DONE. There is no queuing; the requester must wait for IDLE (busy=0).
- diff and borrow hold their last value until the next DONE entry or reset. They do not change during SHIFT.
- Arithmetic: pure unsigned modular subtraction. No signed overflow flag.
- WIDTH=1 is legal: SHIFT lasts exactly one edge.
- cnt width: clog2(WIDTH) bits, minimum 1.

## Timing
- Reset: the rst=1 edge forces state=IDLE, busy=0, done=0, diff=0, borrow=0, and internal registers to 0.
- rst overrides start on the same edge.
- Reset mid-SHIFT or mid-DONE aborts the operation with no done pulse.
- Latency: start accepted at edge k.
  - busy=1 after edge k.
  - Bits are processed at edges k+1 … k+WIDTH.
  - done=1 and the new diff/borrow appear after edge k+WIDTH.
  - done, busy=0 after edge k+WIDTH+1.
- Throughput: one operation per WIDTH+2 cycles. The next start can be accepted at edge k+WIDTH+2 at the earliest.
- busy is high for exactly WIDTH+1 cycles per operation, covering SHIFT and DONE.
- done is high for exactly one cycle, coincident with state DONE.
- All outputs are registered; no combinational path from inputs to outputs.
- a and b are don't-care except on the accept edge.

## Structure
- Shared package serial_arith_pkg:
  - state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2 (2'd3 unreachable; it decodes to IDLE on the next edge).
  - a clog2 helper function used for the cnt width.
- One sub-module: full_subtractor.
  - Combinational cell with inputs x, y, bin and outputs d, bout.
  - Instantiated once for the per-bit step. It is also reusable by later ripple designs.
- Top level holds the FSM, the shift registers, cnt, bw and the output registers.

## Test plan
All scenarios use WIDTH=8.
1. Reset, then start with a=0x05, b=0x03 at edge k → done pulse after edge k+8 with diff=0x02, borrow=0; busy high for 9 cycles.
2. a=0x03, b=0x05 → diff=0xFE, borrow=1; diff/borrow hold through the following IDLE cycles.
3. Corner operands, run back-to-back with start reasserted the first cycle busy=0:
   - a=0x00, b=0x00 → diff=0x00, borrow=0.
   - a=0x00, b=0xFF → diff=0x01, borrow=1.
   - a=0xFF, b=0x00 → diff=0xFF, borrow=0.
4. Pulse start with a=0xAA, b=0x55 at edges k+2 and k+9 during an operation started with a=0x10, b=0x01 → only one done, diff=0x0F, borrow=0; the later pulses are ignored.
5. Assert rst at edge k+4 of an operation → after that edge busy=0, done=0, diff=0, borrow=0, and no done pulse follows. A fresh start with a=0x80, b=0x01 then yields diff=0x7F, borrow=0.
6. Random a/b for 1000 operations → diff == (a−b)&0xFF and borrow == (a<b) on every done; done count equals accepted start count.
